// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the five-stage pipeline.
// Owns the PC and issues one request at a time to instruction memory over a
// req/gnt/rvalid handshake. It feeds the IF/ID register and absorbs ID stalls
// in a one-entry skid buffer. A taken branch from EXE redirects the PC and
// flushes all in-flight work.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   hazard_detected     ID stalled, IF/ID must hold
//   branch_taken        redirect request from EXE
//   branch_addr         redirect target (word aligned)
//   imem_req/imem_addr  fetch request, address equals pc
//   imem_gnt            request accepted
//   imem_rvalid/rdata   fetch response, one per grant
//   id_valid/id_instr   IF/ID payload (valid=0 is a bubble)
//   id_pc               IF/ID fetch address + 4
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_detected,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_KILL  = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [XLEN-1:0]   pc, pc_nx;
    logic [XLEN-1:0]   req_addr, req_addr_nx;
    logic              sk_valid, sk_valid_nx;
    logic [XLEN-1:0]   sk_instr, sk_instr_nx;
    logic [XLEN-1:0]   sk_pc, sk_pc_nx;
    logic              id_valid_nx;
    logic [XLEN-1:0]   id_instr_nx, id_pc_nx;
    logic              rsp_keep;
    logic [XLEN-1:0]   rsp_pc;

    assign imem_addr = pc;

    // Next-state, request generation and IF/ID / skid update.
    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        req_addr_nx = req_addr;
        sk_valid_nx = sk_valid;
        sk_instr_nx = sk_instr;
        sk_pc_nx    = sk_pc;
        id_valid_nx = id_valid;
        id_instr_nx = id_instr;
        id_pc_nx    = id_pc;
        imem_req    = 1'b0;
        rsp_keep    = 1'b0;
        rsp_pc      = req_addr + XLEN'(4);

        case (state)
            S_ISSUE: begin
                // A full skid buffer blocks issue, so at most one word is ever in flight.
                imem_req = rst && !sk_valid && !branch_taken;
                if (imem_req && imem_gnt) begin
                    req_addr_nx = pc;
                    pc_nx       = pc + XLEN'(4);
                    state_nx    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_nx = S_ISSUE;
                    rsp_keep = !branch_taken;
                end else if (branch_taken) begin
                    state_nx = S_KILL;
                end
            end
            S_KILL: begin
                // The response to a flushed request still arrives and is dropped.
                if (imem_rvalid) begin
                    state_nx = S_ISSUE;
                end
            end
            default: state_nx = S_ISSUE;
        endcase

        // Branch outranks hazard: the branching instruction is older than the stalled one.
        if (branch_taken) begin
            id_valid_nx = 1'b0;
            sk_valid_nx = 1'b0;
            pc_nx       = branch_addr;
        end else if (hazard_detected) begin
            if (rsp_keep) begin
                sk_valid_nx = 1'b1;
                sk_instr_nx = imem_rdata;
                sk_pc_nx    = rsp_pc;
            end
        end else if (sk_valid) begin
            id_valid_nx = 1'b1;
            id_instr_nx = sk_instr;
            id_pc_nx    = sk_pc;
            sk_valid_nx = 1'b0;
            if (rsp_keep) begin
                sk_valid_nx = 1'b1;
                sk_instr_nx = imem_rdata;
                sk_pc_nx    = rsp_pc;
            end
        end else if (rsp_keep) begin
            id_valid_nx = 1'b1;
            id_instr_nx = imem_rdata;
            id_pc_nx    = rsp_pc;
        end else begin
            id_valid_nx = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_ISSUE;
            pc       <= RESET_PC;
            req_addr <= '0;
            sk_valid <= 1'b0;
            sk_instr <= '0;
            sk_pc    <= '0;
            id_valid <= 1'b0;
            id_instr <= '0;
            id_pc    <= '0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            req_addr <= req_addr_nx;
            sk_valid <= sk_valid_nx;
            sk_instr <= sk_instr_nx;
            sk_pc    <= sk_pc_nx;
            id_valid <= id_valid_nx;
            id_instr <= id_instr_nx;
            id_pc    <= id_pc_nx;
        end
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline: owns the PC, issues one-at-a-time requests to the instruction memory over a request/grant/response handshake, and drives the IF/ID pipeline register consumed by the decode stage. It is the direct consumer of the hazard unit's `hazard_detected` output, which freezes IF/ID. It absorbs the resulting back-pressure in a one-entry skid buffer. Taken branches from EXE redirect the PC and flush everything in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `hazard_detected`  in  1  from the hazard unit; 1 = ID stalled, IF/ID must hold.
- `branch_taken`  in  1  from EXE; redirect and flush.
- `branch_addr`  in  32  redirect target, word aligned.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  request address; equals `pc`.
- `imem_gnt`  in  1  request accepted when `imem_req && imem_gnt`.
- `imem_rvalid`  in  1  response valid; exactly one per grant, at least 1 cycle after it.
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`.
- `id_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `id_instr`  out  32  IF/ID instruction.
- `id_pc`  out  32  IF/ID fetch address + 4.

## Operation
- Registers: `pc`, `req_addr` (address of the outstanding request), `state`, skid buffer (`sk_valid`, `sk_instr`, `sk_pc`), and IF/ID (`id_valid`, `id_instr`, `id_pc`).
- FSM states:
  - ISSUE: `imem_req` = !`sk_valid` && !`branch_taken`.
    - On grant: `req_addr` <= `pc`, `pc` <= `pc` + 4, go to WAIT.
    - `imem_rvalid` is ignored in ISSUE.
  - WAIT: `imem_req` = 0.
    - On `imem_rvalid` with no branch: deliver the response, go to ISSUE.
    - On `branch_taken` without `imem_rvalid`: go to KILL.
    - On `branch_taken` with `imem_rvalid`: discard the response, go to ISSUE.
  - KILL: `imem_req` = 0. On `imem_rvalid`: discard, go to ISSUE.
- Delivery of a response: word = `imem_rdata`, pc field = `req_addr` + 4.
  - If IF/ID advances this cycle and the skid buffer is empty, the word goes to IF/ID.
  - Otherwise it goes to the skid buffer. The buffer cannot overflow: issue is blocked while `sk_valid`, and only one request is ever outstanding.
- IF/ID update, in priority order:
  1. `branch_taken`: `id_valid` <= 0 and `sk_valid` <= 0. `pc` <= `branch_addr`, overriding any same-cycle increment.
  2. `hazard_detected`: IF/ID holds.
  3. Otherwise load from skid if `sk_valid` (and clear it); else from the delivered response; else `id_valid` <= 0.
- Branch has priority over hazard: a branch in EXE is older than the stalled ID instruction.
- Arithmetic: 32-bit, wraps modulo 2^32. `pc`[1:0] is never altered; `branch_addr` is assumed aligned by EXE.

## Timing
- Reset, while `rst` = 0 at the edge:
  - `pc` = `RESET_PC`, `state` = ISSUE, `sk_valid` = 0.
  - `id_valid` = 0, `id_instr` = 0, `id_pc` = 0.
  - `imem_req` is forced to 0 combinationally while `rst` = 0.
- Reset in any state abandons any outstanding request. The instruction memory shares `rst`, so no stale response follows.
- Best case: grant in the issue cycle and `rvalid` on the next cycle gives one instruction every 2 cycles. The instruction is visible on IF/ID the cycle after `rvalid`.
- While `imem_gnt` = 0: `imem_req` stays 1 and `imem_addr` stays stable, unless a branch redirects.
- Branch in ISSUE: no request that cycle. The first request to `branch_addr` goes out the next cycle.
- Branch while `hazard_detected` = 1: the flush still occurs and `id_valid` = 0 on the next cycle.

## Test plan
- **Straight-line fetch**
  - Stimulus: reset; `gnt` = 1 always; `rvalid` 1 cycle after grant; `rdata` = address.
  - Required: `id_instr` = 0, 4, 8 with `id_pc` = 4, 8, 12, `id_valid` pulsing every other cycle.
- **Hazard stall**
  - Stimulus: `hazard_detected` = 1 for 4 cycles while `id_instr` = 0x4.
  - Required: IF/ID holds 0x4; the response 0x8 lands in skid; no `imem_req` while skid is full.
  - Required: after release, IF/ID = 0x8 then 0xC; no word lost or duplicated.
- **Branch while waiting**
  - Stimulus: branch to 0x100 in WAIT with `rvalid` 3 cycles later.
  - Required: the late response is discarded; next `imem_addr` = 0x100; `id_pc` = 0x104 on delivery.
- **Branch coincident with response**
  - Stimulus: `branch_taken` in the same cycle as `imem_rvalid`, with `hazard_detected` = 1.
  - Required: response dropped, `id_valid` = 0 next cycle, next request to `branch_addr`.
- **Grant back-pressure**
  - Stimulus: `gnt` = 0 for 5 cycles.
  - Required: `imem_req` = 1 and `imem_addr` constant throughout; `pc` advances by 4 only on the granting cycle.
- **Reset mid-operation**
  - Stimulus: `rst` = 0 in WAIT with skid full.
  - Required: all outputs return to reset values next cycle; the first request after reset is to `RESET_PC`.
